// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: opcodes, instruction fields, sequencer states.
package cpu_pkg;
  localparam int CPU_NREG = 4;
  localparam int CPU_DW   = 4;
  localparam int INSTR_W  = 11;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;
  localparam logic [3:0] OP_LT  = 4'd13;
  localparam logic [3:0] OP_GT  = 4'd14;
  localparam logic [3:0] OP_EQ  = 4'd15;

  // Field LSB positions; LI instructions reuse [3:0] as the immediate.
  localparam int LI_BIT  = 10;
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RA_LSB  = 2;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [CPU_DW-1:0] DIV_ZERO_RESULT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;
endpackage

// File: rtl/cpu_regfile.sv
// General register file: two async read ports, a debug read port, one sync write port.
module cpu_regfile #(
  parameter int NREG = 4,
  parameter int DW   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NREG)-1:0]  raddr_a,
  output logic [DW-1:0]            rdata_a,
  input  logic [$clog2(NREG)-1:0]  raddr_b,
  output logic [DW-1:0]            rdata_b,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DW-1:0]            dbg_data
);
  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// Sequential core of the 4-bit CPU: accepts instructions, drives the external ALU,
// writes results back. Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int NREG = CPU_NREG,
  parameter int DW   = CPU_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [3:0]               alu_sel,
  input  logic [DW-1:0]            alu_out,
  input  logic                     alu_carry,
  output logic                     result_valid,
  output logic [DW-1:0]            result,
  output logic [$clog2(NREG)-1:0]  result_rd,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     div_err,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DW-1:0]            dbg_data
);
  localparam int AW = $clog2(NREG);

  state_t        state, state_nxt;
  logic          li_q, carry_q;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] a_q, b_q, res_q;
  logic [DW-1:0] rf_a, rf_b;
  logic          accept, div_zero, wb_we;

  assign accept   = instr_valid && instr_ready;
  assign div_zero = (op_q == OP_DIV) && (b_q == '0);
  assign wb_we    = (state == WB);

  cpu_regfile #(.NREG(NREG), .DW(DW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr_a  (instr[RA_LSB +: AW]),
    .rdata_a  (rf_a),
    .raddr_b  (instr[RB_LSB +: AW]),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = instr[LI_BIT] ? WB : EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state == IDLE);
    result_valid = (state == WB);
    alu_a        = '0;
    alu_b        = '0;
    alu_sel      = '0;
    if (state == EXEC) begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sel = op_q;
    end
  end

  // Operands are captured at acceptance, so a writeback to ra/rb cannot disturb them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      li_q    <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      div_err <= 1'b0;
    end else begin
      if (accept) begin
        li_q <= instr[LI_BIT];
        op_q <= instr[OP_LSB +: 4];
        rd_q <= instr[RD_LSB +: AW];
        if (instr[LI_BIT]) res_q <= instr[IMM_LSB +: DW];
        else begin
          a_q <= rf_a;
          b_q <= rf_b;
        end
      end
      if (state == EXEC) begin
        carry_q <= alu_carry;
        if (div_zero) begin
          res_q   <= DIV_ZERO_RESULT;
          div_err <= 1'b1;
        end else begin
          res_q <= alu_out;
        end
      end
      if (state == WB) begin
        flag_z <= (res_q == '0);
        if (!li_q && op_q == OP_ADD) flag_c <= carry_q;
      end
    end
  end

  assign result    = res_q;
  assign result_rd = rd_q;
endmodule
